// File: rtl/async_fifo_wr_arbiter_pkg.sv
// Shared definitions for the async FIFO write-side arbiter slice.
// This package holds the FSM encoding, the register width helpers and the stall counter width.
// Optional feature macro used elsewhere in the slice: ASYNC_FIFO_ARB_STALL_CNT_EN.
package async_fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int STALL_CNT_W = 16;

  // Width of an index over n requesters. A single requester still needs one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The beat counter must be able to hold the value max_burst itself.
  function automatic int beat_cnt_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_if.sv
// Requester / FIFO write-port bundle for async_fifo_wr_arbiter.
// master: the requesters and the FIFO status side. slave: the arbiter.
interface async_fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic                          fifo_full;
  logic [NUM_REQ-1:0]            grant;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data;
  logic                          busy;

  modport master (
    output req, req_data, req_last, fifo_full,
    input  grant, fifo_wr_en, fifo_data, busy
  );

  modport slave (
    input  req, req_data, req_last, fifo_full,
    output grant, fifo_wr_en, fifo_data, busy
  );
endinterface

// File: rtl/async_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first active request
// scanning last_owner+1, last_owner+2, ... with wrap-around.
module rr_pick
  import async_fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OW      = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [OW-1:0]      last_owner_i,
  output logic [OW-1:0]      pick_o,
  output logic               valid_o
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_rot;

  // Rotate a doubled copy so that bit 0 is the requester after last_owner.
  always_comb begin
    req_dbl = {req_i, req_i};
    req_rot = req_dbl >> (last_owner_i + 1'b1);
  end

  // Take the lowest set bit of the rotated view and map it back to an index.
  always_comb begin : scan
    int p;
    p       = 0;
    pick_o  = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && req_rot[i]) begin
        p = int'(last_owner_i) + 1 + i;
        if (p >= NUM_REQ) p = p - NUM_REQ;
        pick_o  = OW'(p);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Write-side scheduler that shares one async FIFO write port among NUM_REQ requesters.
// The scheduler arbitrates round-robin. A granted requester keeps the port until its last beat or MAX_BURST beats.
// When ASYNC_FIFO_ARB_STALL_CNT_EN is defined, an extra stall_cnt output counts cycles stalled on fifo_full.
module async_fifo_wr_arbiter
  import async_fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk_w,
  input  logic                    rst,
  async_fifo_wr_arbiter_if.slave  wr_if
`ifdef ASYNC_FIFO_ARB_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]  stall_cnt
`endif
);

  localparam int OW = owner_w(NUM_REQ);
  localparam int BW = beat_cnt_w(MAX_BURST);

  arb_state_t            state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         last_owner_q, last_owner_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]         pick;
  logic                  pick_vld;
  logic                  own_req;
  logic                  own_last;
  logic                  accept;
  logic [DATA_WIDTH-1:0] slice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice[g] = wr_if.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OW      (OW)
  ) u_rr_pick (
    .req_i        (wr_if.req),
    .last_owner_i (last_owner_q),
    .pick_o       (pick),
    .valid_o      (pick_vld)
  );

  // Owner-side status and the beat-accept condition.
  always_comb begin
    own_req  = wr_if.req[owner_q];
    own_last = wr_if.req_last[owner_q];
    accept   = (state_q == BURST) && own_req && !wr_if.fifo_full;
  end

  // State register. Asynchronous reset makes last_owner point at the top index, so requester 0 wins first.
  always_ff @(posedge clk_w or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Next-state logic. A burst ends on a last beat, at the burst limit, or when the owner withdraws.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = BURST;
          owner_d    = pick;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (own_last || ((beat_cnt_q + 1'b1) == BW'(MAX_BURST))) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
          end
        end else if (!own_req) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Everything is zero in IDLE or under reset. The owner's data is presented throughout BURST.
  always_comb begin
    wr_if.grant      = '0;
    wr_if.fifo_wr_en = 1'b0;
    wr_if.fifo_data  = '0;
    wr_if.busy       = 1'b0;
    if (!rst && (state_q == BURST)) begin
      wr_if.busy           = 1'b1;
      wr_if.fifo_data      = slice[owner_q];
      wr_if.grant[owner_q] = accept;
      wr_if.fifo_wr_en     = accept;
    end
  end

`ifdef ASYNC_FIFO_ARB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles where the owner has a beat ready but the FIFO is full.
  always_ff @(posedge clk_w or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == BURST) && own_req && wr_if.fifo_full && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/async_fifo_wr_arbiter.md
Name: async_fifo_wr_arbiter

Overview:
Write-side scheduler that shares the single write port of the async FIFO among NUM_REQ requesters in the clk_w domain.
- Round-robin arbitration with burst locking: a granted requester owns the port until its last beat or MAX_BURST beats.
- Backpressure comes from the FIFO full flag, so no write is ever dropped.
- Sits directly in front of the FIFO wr_en/data_in pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, FIFO word width; must match the FIFO instance.
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration (1..16).

Ports:
- clk_w  in  1  FIFO write clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester "beat valid"; held with data until granted.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; slice i belongs to requester i.
- req_last  in  NUM_REQ  marks the current beat as last of a packet.
- fifo_full  in  1  FIFO full flag (clk_w domain).
- grant  out  NUM_REQ  one-hot beat-accept strobe, combinational.
- fifo_wr_en  out  1  FIFO write enable, combinational.
- fifo_data  out  DATA_WIDTH  FIFO write data, muxed from the owner.
- busy  out  1  high while in BURST.

Behaviour:
- FSM states: IDLE, BURST. Registers: state, owner (clog2 NUM_REQ), last_owner, beat_cnt (clog2 MAX_BURST + 1).
- Reset values:
  - state=IDLE, owner=0, last_owner=NUM_REQ-1 (requester 0 wins first), beat_cnt=0.
  - grant=0, fifo_wr_en=0, fifo_data=0, busy=0.
- IDLE:
  - Outputs are 0.
  - If |req, pick the first requesting index scanning last_owner+1, +2, ... with modulo NUM_REQ wrap.
  - Next edge: owner=pick, beat_cnt=0, state=BURST. This costs one arbitration bubble cycle.
- BURST:
  - accept = req[owner] & !fifo_full.
  - grant[owner] = accept. fifo_wr_en = accept. fifo_data = req_data slice[owner] at all times in BURST, 0 in IDLE.
  - On accept: beat_cnt++.
  - Burst ends (state=IDLE, last_owner=owner) on an accepted beat with req_last[owner]=1, or when beat_cnt+1==MAX_BURST.
- Full stall: fifo_full=1 in BURST gives no grant. beat_cnt, owner and state hold; the burst resumes when full drops.
- Owner withdraw: req[owner]=0 in BURST with no accept ends the burst next edge. last_owner=owner, no write.
- Simultaneous: req_last together with the MAX_BURST limit gives a single end of burst. Requests from non-owners are ignored until IDLE.
- Non-owner grants are always 0. grant is never asserted while fifo_full=1.
- Reset mid-burst: immediate return to reset values. A beat presented in the reset cycle is not written.
- Latency: first write occurs ≥1 cycle after req rises from IDLE. Steady-state throughput is 1 beat/cycle within a burst.

Optional Feature:
- Macro ASYNC_FIFO_ARB_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0].
  - Increments each cycle with state==BURST & req[owner] & fifo_full.
  - Saturates at 16'hFFFF. Reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package async_fifo_pkg:
  - FSM state encoding constants IDLE=1'b0, BURST=1'b1.
  - Shared width helpers: owner width = clog2 NUM_REQ; beat_cnt width.
  - Stall counter width constant 16.
- Sub-module rr_pick (combinational): inputs req vector and last_owner; outputs pick index and valid. Separately testable.

Test Plan:
1. Reset then req=4'b0001, req_last[0] high on 3rd beat, full=0 -> IDLE 1 cycle, then grant[0] for 3 consecutive cycles with fifo_data matching beats 0..2, then IDLE.
2. req=4'b1111 held, never last, MAX_BURST=4 -> owner order 0,1,2,3,0. Exactly 4 writes per owner, 1 bubble between bursts.
3. Owner 2 in BURST, fifo_full high 5 cycles after beat 1 -> grant=0 for 5 cycles, beat_cnt holds at 1, remaining 3 beats written after full drops. With macro defined, stall_cnt=5.
4. Owner 1 drops req after 2 beats -> burst ends, next pick starts scan at index 2 (req=4'b0011 gives owner 0).
5. rst asserted mid-burst at beat 2 of owner 3 -> all outputs 0 in the same cycle. After release with req=4'b1000, owner 3 is granted again after 1 IDLE cycle.
6. req_last on beat 4 with MAX_BURST=4 -> single burst end, exactly 4 writes, no extra write or bubble anomaly.
